mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- ADDR_LEN, 5, memory address width.
- WORD_SIZE, 32, memory data width.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning. N = 0, 1 denotes one port per requester.
- clk, in, 1, single clock, rising edge.
- rst, in, 1, synchronous active-high reset.
- reqN, in, 1, requester N access request.
- weN, in, 1, requester N write (1) or read (0).
- addrN, in, ADDR_LEN, requester N address.
- wdataN, in, WORD_SIZE, requester N write data.
- gntN, out, 1, one-cycle accept pulse to requester N.
- doneN, out, 1, one-cycle completion pulse to requester N.
- rdataN, out, WORD_SIZE, requester N read data, valid while doneN=1 for a read.
- mem_r_addr / mem_w_addr, out, ADDR_LEN, memory read / write address.
- mem_r_en / mem_w_en, out, 1, memory read / write enable.
- mem_data_in, out, WORD_SIZE, memory write data.
- mem_data_out, in, WORD_SIZE, memory read data (combinational from mem_r_addr).

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, ACCESS, RESP.
REQ-004 In IDLE with any reqN=1, the arbiter SHALL pulse exactly one gntN, latch that requester's we/addr/wdata and its index, and enter ACCESS next cycle.
REQ-005 A request SHALL be accepted only in the cycle its gntN=1; reqN is level-sensitive and is held by the requester until granted.
REQ-006 In ACCESS, the arbiter SHALL assert exactly one of mem_r_en or mem_w_en for one cycle, drive both addresses from the latched addr and drive mem_data_in from the latched wdata.
REQ-007 For a read, the arbiter SHALL register mem_data_out at the end of ACCESS into rdata of the latched requester.
REQ-008 In RESP, the arbiter SHALL pulse doneN of the latched requester for one cycle and return to IDLE.
REQ-009 Latency SHALL be fixed: gnt in cycle T, memory strobe in T+1, done in T+2; the next grant is no earlier than T+3.
REQ-010 mem_r_en and mem_w_en SHALL never be high together; both SHALL be 0 outside ACCESS.
REQ-011 gnt0 and gnt1 SHALL be mutually exclusive; so SHALL done0 and done1.
REQ-012 rdataN SHALL hold its last value until the next read completion for requester N; a write completion SHALL leave rdataN unchanged.
REQ-013 With a single active requester, that requester SHALL be granted each time IDLE is entered.
REQ-014 Request changes during ACCESS or RESP SHALL have no effect on the transaction in flight.

Reset
REQ-015 rst sampled high SHALL force state to IDLE and set gnt0/1, done0/1, mem_r_en and mem_w_en to 0, rdata0/1 and mem_data_in to 0, both memory addresses to 0, and the last-winner pointer to requester 1 (requester 0 wins first).
REQ-016 rst asserted during ACCESS SHALL deassert the memory strobes in the next cycle; no done pulse SHALL be issued for the aborted transaction.

Configuration
REQ-017 With macro MEM_ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL be granted to the requester not granted last; the pointer updates on each grant.
REQ-018 Without MEM_ARB_ROUND_ROBIN_EN, simultaneous requests SHALL always be granted to requester 0 (fixed priority); the pointer logic SHALL be absent.

Verification
REQ-019 Reset, then req0=1, we0=1, addr0=3, wdata0=0xDEADBEEF -> gnt0 in T, mem_w_en=1 with mem_w_addr=3 in T+1, done0 in T+2.
REQ-020 Following REQ-019, req1=1, we1=0, addr1=3 -> mem_r_en=1 in T+1; done1=1 with rdata1=0xDEADBEEF in T+2; rdata0 unchanged.
REQ-021 req0 and req1 held high continuously, 4 transactions -> with macro: grants 0,1,0,1; without macro: grants 0,0,0,0.
REQ-022 rst pulsed one cycle during ACCESS of a write to addr 7 -> mem_w_en low the next cycle, no done pulse, state IDLE, requester 0 wins the next contested grant.
REQ-023 Random req/we traffic for 1000 cycles -> never both enables high, never two gnt or two done in one cycle, exactly one done per gnt absent reset.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the two requester channels and the memory bus of mem_arbiter.
// Parameters: ADDR_LEN (address width), WORD_SIZE (data width).
// slave modport  : the arbiter side (takes requests and read data, drives grants, completions and memory strobes).
// master modport : the environment side (requesters plus memory model).
interface mem_arbiter_if #(
    parameter int ADDR_LEN  = 5,
    parameter int WORD_SIZE = 32
);
    logic                 req0, req1, we0, we1;
    logic [ADDR_LEN-1:0]  addr0, addr1;
    logic [WORD_SIZE-1:0] wdata0, wdata1;
    logic                 gnt0, gnt1, done0, done1;
    logic [WORD_SIZE-1:0] rdata0, rdata1;
    logic [ADDR_LEN-1:0]  mem_r_addr, mem_w_addr;
    logic                 mem_r_en, mem_w_en;
    logic [WORD_SIZE-1:0] mem_data_in, mem_data_out;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_data_out,
        output gnt0, gnt1, done0, done1, rdata0, rdata1,
               mem_r_addr, mem_w_addr, mem_r_en, mem_w_en, mem_data_in
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_data_out,
        input  gnt0, gnt1, done0, done1, rdata0, rdata1,
               mem_r_addr, mem_w_addr, mem_r_en, mem_w_en, mem_data_in
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester single-port memory arbiter with fixed 3-cycle transactions (grant, strobe, done).
// Ports: clk (rising edge), rst (sync active-high), bus (mem_arbiter_if.slave: req/we/addr/wdata in,
//        gnt/done/rdata out per requester; mem_r_addr/mem_w_addr/mem_r_en/mem_w_en/mem_data_in out, mem_data_out in).
// Config: define MEM_ARB_ROUND_ROBIN_EN for round-robin on contention; default is fixed priority to requester 0.
module mem_arbiter #(
    parameter int ADDR_LEN  = 5,
    parameter int WORD_SIZE = 32
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t               state_q, state_d;
    logic                 idx_q, idx_d, we_q, we_d;
    logic [ADDR_LEN-1:0]  addr_q, addr_d;
    logic [WORD_SIZE-1:0] wdata_q, wdata_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic                 grant, pick, rd_cap;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_q, last_d;
    // on contention the requester that did not win last time goes next
    assign pick   = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
    assign last_d = grant ? pick : last_q;
    always_ff @(posedge clk) begin
        if (rst) last_q <= 1'b1;
        else     last_q <= last_d;
    end
`else
    assign pick = ~bus.req0;
`endif

    // grant is suppressed while rst is high so nothing is accepted in a reset cycle
    assign grant  = !rst && state_q == IDLE && (bus.req0 || bus.req1);
    assign rd_cap = state_q == ACCESS && !we_q;

    always_comb begin
        state_d  = grant ? ACCESS : (state_q == ACCESS ? RESP : IDLE);
        idx_d    = grant ? pick : idx_q;
        we_d     = grant ? (pick ? bus.we1 : bus.we0) : we_q;
        addr_d   = grant ? (pick ? bus.addr1 : bus.addr0) : addr_q;
        wdata_d  = grant ? (pick ? bus.wdata1 : bus.wdata0) : wdata_q;
        rdata0_d = (rd_cap && !idx_q) ? bus.mem_data_out : rdata0_q;
        rdata1_d = (rd_cap && idx_q) ? bus.mem_data_out : rdata1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign bus.gnt0        = grant && !pick;
    assign bus.gnt1        = grant && pick;
    assign bus.mem_r_en    = state_q == ACCESS && !we_q;
    assign bus.mem_w_en    = state_q == ACCESS && we_q;
    assign bus.mem_r_addr  = addr_q;
    assign bus.mem_w_addr  = addr_q;
    assign bus.mem_data_in = wdata_q;
    assign bus.done0       = state_q == RESP && !idx_q;
    assign bus.done1       = state_q == RESP && idx_q;
    assign bus.rdata0      = rdata0_q;
    assign bus.rdata1      = rdata1_q;
endmodule
